// File: rtl/vram_arbiter.sv
// Slot arbiter for the shared SRAM: the screen fetcher owns any slot it asks for,
// and the CPU and secondary requesters share the remaining 2-cycle slots round-robin.
module vram_arbiter #(
  parameter int RAM_AW = 19
) (
  input  logic              clk28,
  input  logic              rst_n,
  input  logic              ck14,
  input  logic              screen_page,
  input  logic              scr_fetch_next,
  output logic              scr_fetch_allow,
  input  logic [14:0]       scr_addr,
  output logic [7:0]        scr_fetch_data,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [RAM_AW-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
  input  logic              ext_req,
  input  logic              ext_wr,
  input  logic [RAM_AW-1:0] ext_addr,
  input  logic [7:0]        ext_wdata,
  output logic [7:0]        ext_rdata,
  output logic              ext_ack,
  output logic [RAM_AW-1:0] ram_a,
  output logic [7:0]        ram_dq_out,
  output logic              ram_dq_oe,
  input  logic [7:0]        ram_dq_in,
  output logic              ram_we_n,
  output logic              ram_oe_n
);

  typedef enum logic [1:0] {
    OWN_IDLE,
    OWN_SCR,
    OWN_CPU,
    OWN_EXT
  } own_t;

  own_t              own_q, own_d;
  logic              lastExt_q, lastExt_d;
  logic [RAM_AW-1:0] ramA_q, ramA_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              cpuAck_q, cpuAck_d;
  logic              extAck_q, extAck_d;
  logic [7:0]        cpuRdata_q, cpuRdata_d;
  logic [7:0]        extRdata_q, extRdata_d;

  logic              cpuPend;
  logic              extPend;
  logic [RAM_AW-1:0] scrRamAddr;
  logic              reqSlot;
  logic              readSlot;
  logic              writeSlot;
  logic              unusedScrBit;

  // Bank 5 sits at 0x14000 and bank 7 at 0x1C000; bit 14 of the screen address is not used.
  assign scrRamAddr   = RAM_AW'({2'b01, screen_page, 1'b1, scr_addr[13:0]});
  assign unusedScrBit = scr_addr[14];

  assign scr_fetch_allow = scr_fetch_next;
  assign scr_fetch_data  = ram_dq_in;

  // A request still high on the boundary that closes its own slot is the one being acked, not a new one.
  assign cpuPend = cpu_req && (own_q != OWN_CPU) && !cpuAck_q;
  assign extPend = ext_req && (own_q != OWN_EXT) && !extAck_q;

  always_comb begin
    own_d     = own_q;
    lastExt_d = lastExt_q;
    ramA_d    = ramA_q;
    wdata_d   = wdata_q;
    wr_d      = wr_q;
    if (ck14) begin
      if (scr_fetch_next) begin
        own_d  = OWN_SCR;
        ramA_d = scrRamAddr;
        wr_d   = 1'b0;
      end else if (cpuPend && (!extPend || lastExt_q)) begin
        own_d     = OWN_CPU;
        lastExt_d = 1'b0;
        ramA_d    = cpu_addr;
        wdata_d   = cpu_wdata;
        wr_d      = cpu_wr;
      end else if (extPend) begin
        own_d     = OWN_EXT;
        lastExt_d = 1'b1;
        ramA_d    = ext_addr;
        wdata_d   = ext_wdata;
        wr_d      = ext_wr;
      end else begin
        own_d = OWN_IDLE;
        wr_d  = 1'b0;
      end
    end
  end

  // Completion: a requester that dropped its request mid-slot gets neither ack nor data.
  always_comb begin
    cpuAck_d   = ck14 && (own_q == OWN_CPU) && cpu_req;
    extAck_d   = ck14 && (own_q == OWN_EXT) && ext_req;
    cpuRdata_d = cpuRdata_q;
    extRdata_d = extRdata_q;
    if (cpuAck_d && !wr_q) begin
      cpuRdata_d = ram_dq_in;
    end
    if (extAck_d && !wr_q) begin
      extRdata_d = ram_dq_in;
    end
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      own_q      <= OWN_IDLE;
      lastExt_q  <= 1'b1;
      ramA_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      cpuAck_q   <= 1'b0;
      extAck_q   <= 1'b0;
      cpuRdata_q <= '0;
      extRdata_q <= '0;
    end else begin
      own_q      <= own_d;
      lastExt_q  <= lastExt_d;
      ramA_q     <= ramA_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      cpuAck_q   <= cpuAck_d;
      extAck_q   <= extAck_d;
      cpuRdata_q <= cpuRdata_d;
      extRdata_q <= extRdata_d;
    end
  end

  // Strobes decode straight from the owner register so an asynchronous reset releases the bus at once.
  always_comb begin
    reqSlot   = (own_q == OWN_CPU) || (own_q == OWN_EXT);
    writeSlot = reqSlot && wr_q;
    readSlot  = (own_q == OWN_SCR) || (reqSlot && !wr_q);
  end

  assign ram_a      = ramA_q;
  assign ram_dq_out = wdata_q;
  assign ram_dq_oe  = writeSlot;
  assign ram_oe_n   = !readSlot;
  assign ram_we_n   = !(writeSlot && ck14);

  assign cpu_ack   = cpuAck_q;
  assign ext_ack   = extAck_q;
  assign cpu_rdata = cpuRdata_q;
  assign ext_rdata = extRdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a byte-wide SRAM model behind the arbiter.
module tb_vram_arbiter;

  localparam int RAM_AW = 19;

  logic              clk28 = 1'b0;
  logic              rst_n = 1'b0;
  logic              ck14 = 1'b0;
  logic              screen_page;
  logic              scr_fetch_next;
  logic              scr_fetch_allow;
  logic [14:0]       scr_addr;
  logic [7:0]        scr_fetch_data;
  logic              cpu_req, cpu_wr;
  logic [RAM_AW-1:0] cpu_addr;
  logic [7:0]        cpu_wdata, cpu_rdata;
  logic              cpu_ack;
  logic              ext_req, ext_wr;
  logic [RAM_AW-1:0] ext_addr;
  logic [7:0]        ext_wdata, ext_rdata;
  logic              ext_ack;
  logic [RAM_AW-1:0] ram_a;
  logic [7:0]        ram_dq_out, ram_dq_in;
  logic              ram_dq_oe, ram_we_n, ram_oe_n;

  logic [7:0] mem [0:(1<<RAM_AW)-1];

  int vectors = 0;
  int miscompares = 0;
  int cpuAckCount = 0;
  int extAckCount = 0;
  int cpuBase, extBase;

  vram_arbiter #(.RAM_AW(RAM_AW)) dut (
    .clk28(clk28), .rst_n(rst_n), .ck14(ck14),
    .screen_page(screen_page), .scr_fetch_next(scr_fetch_next),
    .scr_fetch_allow(scr_fetch_allow), .scr_addr(scr_addr), .scr_fetch_data(scr_fetch_data),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ext_req(ext_req), .ext_wr(ext_wr), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_ack(ext_ack),
    .ram_a(ram_a), .ram_dq_out(ram_dq_out), .ram_dq_oe(ram_dq_oe), .ram_dq_in(ram_dq_in),
    .ram_we_n(ram_we_n), .ram_oe_n(ram_oe_n)
  );

  initial forever #5 clk28 = ~clk28;

  // ck14 changes with the clock edge so it is stable across each whole cycle.
  initial forever begin
    @(posedge clk28);
    ck14 <= ~ck14;
  end

  assign ram_dq_in = mem[ram_a];

  // SRAM contents default to addr[7:0]^addr[15:8]^0x5A; writes land when WE# is low at an edge.
  initial begin
    for (int i = 0; i < (1 << RAM_AW); i++) begin
      mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
    end
    mem[19'h14001] = 8'hA5;
    forever begin
      @(posedge clk28);
      if (ram_we_n === 1'b0) mem[ram_a] = ram_dq_out;
    end
  end

  always @(posedge clk28) begin
    if (cpu_ack === 1'b1) cpuAckCount++;
    if (ext_ack === 1'b1) extAckCount++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed still running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int sel, input logic req, input logic wr,
                               input logic [RAM_AW-1:0] addr, input logic [7:0] wdata);
    if (sel == 0) begin
      cpu_req = req; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
    end else begin
      ext_req = req; ext_wr = wr; ext_addr = addr; ext_wdata = wdata;
    end
  endtask

  task automatic tick();
    @(posedge clk28);
    #1;
  endtask

  task automatic toBoundary();
    do @(posedge clk28); while (ck14 !== 1'b1);
    #1;
  endtask

  initial begin
    screen_page = 1'b0; scr_fetch_next = 1'b0; scr_addr = '0;
    applyStimulus(0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1, 1'b0, 1'b0, '0, '0);

    repeat (3) @(posedge clk28);
    #1;
    checkOutput("rst_oe_n", ram_oe_n, 1);
    checkOutput("rst_we_n", ram_we_n, 1);
    checkOutput("rst_dq_oe", ram_dq_oe, 0);
    checkOutput("rst_ram_a", ram_a, 0);
    checkOutput("rst_dq_out", ram_dq_out, 0);
    checkOutput("rst_acks", {cpu_ack, ext_ack}, 0);
    checkOutput("rst_rdata", {cpu_rdata, ext_rdata}, 0);
    rst_n = 1'b1;

    // CPU read on an idle bus
    toBoundary();
    applyStimulus(0, 1'b1, 1'b0, 19'h14001, 8'h00);
    toBoundary();
    checkOutput("rd_oe_c1", ram_oe_n, 0);
    checkOutput("rd_ram_a", ram_a, 32'h14001);
    checkOutput("rd_dq_oe", ram_dq_oe, 0);
    checkOutput("rd_we_c1", ram_we_n, 1);
    tick();
    checkOutput("rd_oe_c2", ram_oe_n, 0);
    checkOutput("rd_we_c2", ram_we_n, 1);
    checkOutput("rd_early_ack", cpu_ack, 0);
    tick();
    checkOutput("rd_ack", cpu_ack, 1);
    checkOutput("rd_data", cpu_rdata, 8'hA5);
    checkOutput("rd_idle_oe", ram_oe_n, 1);
    checkOutput("rd_a_hold", ram_a, 32'h14001);
    applyStimulus(0, 1'b0, 1'b0, '0, '0);
    tick();
    checkOutput("rd_ack_off", cpu_ack, 0);
    checkOutput("rd_ack_count", cpuAckCount, 1);

    // CPU write, then read it back
    toBoundary();
    applyStimulus(0, 1'b1, 1'b1, 19'h00010, 8'h3C);
    toBoundary();
    checkOutput("wr_dq_oe_c1", ram_dq_oe, 1);
    checkOutput("wr_dq_out", ram_dq_out, 8'h3C);
    checkOutput("wr_we_c1", ram_we_n, 1);
    checkOutput("wr_oe_n", ram_oe_n, 1);
    checkOutput("wr_ram_a", ram_a, 32'h10);
    tick();
    checkOutput("wr_dq_oe_c2", ram_dq_oe, 1);
    checkOutput("wr_we_c2", ram_we_n, 0);
    tick();
    checkOutput("wr_ack", cpu_ack, 1);
    checkOutput("wr_we_after", ram_we_n, 1);
    checkOutput("wr_dq_oe_after", ram_dq_oe, 0);
    checkOutput("wr_mem", mem[19'h10], 8'h3C);
    applyStimulus(0, 1'b0, 1'b0, '0, '0);
    toBoundary();
    applyStimulus(0, 1'b1, 1'b0, 19'h00010, 8'h00);
    toBoundary();
    tick();
    tick();
    checkOutput("rb_ack", cpu_ack, 1);
    checkOutput("rb_data", cpu_rdata, 8'h3C);
    applyStimulus(0, 1'b0, 1'b0, '0, '0);

    // Screen fetch from bank 7 with a CPU read waiting behind it
    toBoundary();
    screen_page = 1'b1; scr_addr = 15'h4123; scr_fetch_next = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 19'h00020, 8'h00);
    #1;
    checkOutput("scr_allow", scr_fetch_allow, 1);
    toBoundary();
    checkOutput("scr_ram_a", ram_a, 32'h1C123);
    checkOutput("scr_oe_n", ram_oe_n, 0);
    scr_fetch_next = 1'b0;
    #1;
    checkOutput("scr_allow_off", scr_fetch_allow, 0);
    tick();
    checkOutput("scr_data", scr_fetch_data, 8'hB8);
    tick();
    checkOutput("scr_cpu_deferred", cpu_ack, 0);
    checkOutput("scr_cpu_ram_a", ram_a, 32'h20);
    tick();
    tick();
    checkOutput("scr_cpu_ack", cpu_ack, 1);
    checkOutput("scr_cpu_data", cpu_rdata, 8'h7A);
    applyStimulus(0, 1'b0, 1'b0, '0, '0);

    // Secondary requester write
    toBoundary();
    applyStimulus(1, 1'b1, 1'b1, 19'h00300, 8'h99);
    toBoundary();
    checkOutput("ext_ram_a", ram_a, 32'h300);
    checkOutput("ext_dq_out", ram_dq_out, 8'h99);
    tick();
    tick();
    checkOutput("ext_ack", ext_ack, 1);
    checkOutput("ext_no_cpu_ack", cpu_ack, 0);
    checkOutput("ext_mem", mem[19'h300], 8'h99);
    applyStimulus(1, 1'b0, 1'b0, '0, '0);

    // CPU and EXT both requesting: CPU wins the first tie, then strict alternation
    toBoundary();
    cpuBase = cpuAckCount; extBase = extAckCount;
    applyStimulus(0, 1'b1, 1'b0, 19'h00100, 8'h00);
    applyStimulus(1, 1'b1, 1'b0, 19'h00200, 8'h00);
    toBoundary();
    for (int k = 0; k < 8; k++) begin
      toBoundary();
      checkOutput($sformatf("rr_cpu_ack%0d", k), cpu_ack, ((k % 2) == 0) ? 1 : 0);
      checkOutput($sformatf("rr_ext_ack%0d", k), ext_ack, ((k % 2) == 1) ? 1 : 0);
      if ((k % 2) == 0) checkOutput($sformatf("rr_cpu_data%0d", k), cpu_rdata, 8'h5B);
      else checkOutput($sformatf("rr_ext_data%0d", k), ext_rdata, 8'h58);
    end
    applyStimulus(0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1, 1'b0, 1'b0, '0, '0);
    toBoundary();
    checkOutput("rr_dropped_no_ack", cpu_ack, 0);
    tick();
    checkOutput("rr_cpu_count", cpuAckCount - cpuBase, 4);
    checkOutput("rr_ext_count", extAckCount - extBase, 4);

    // 64-slot screen burst from bank 5 with the CPU pending throughout
    toBoundary();
    cpuBase = cpuAckCount;
    screen_page = 1'b0; scr_addr = 15'h7FFF; scr_fetch_next = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 19'h00030, 8'h00);
    toBoundary();
    checkOutput("burst_ram_a", ram_a, 32'h17FFF);
    checkOutput("burst_oe_n", ram_oe_n, 0);
    repeat (63) toBoundary();
    scr_fetch_next = 1'b0;
    checkOutput("burst_cpu_starved", cpuAckCount - cpuBase, 0);
    toBoundary();
    checkOutput("burst_ack_pending", cpu_ack, 0);
    checkOutput("burst_cpu_ram_a", ram_a, 32'h30);
    toBoundary();
    checkOutput("burst_cpu_ack", cpu_ack, 1);
    checkOutput("burst_cpu_data", cpu_rdata, 8'h6A);
    applyStimulus(0, 1'b0, 1'b0, '0, '0);

    // Request withdrawn after grant: no ack, read data untouched
    toBoundary();
    applyStimulus(0, 1'b1, 1'b0, 19'h00050, 8'h00);
    toBoundary();
    checkOutput("drop_oe_n", ram_oe_n, 0);
    applyStimulus(0, 1'b0, 1'b0, '0, '0);
    tick();
    tick();
    checkOutput("drop_no_ack", cpu_ack, 0);
    checkOutput("drop_rdata", cpu_rdata, 8'h6A);

    // Reset in the second cycle of a CPU write
    toBoundary();
    cpuBase = cpuAckCount;
    applyStimulus(0, 1'b1, 1'b1, 19'h00040, 8'h77);
    toBoundary();
    tick();
    checkOutput("rstw_we_before", ram_we_n, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstw_we_n", ram_we_n, 1);
    checkOutput("rstw_dq_oe", ram_dq_oe, 0);
    checkOutput("rstw_rdata", cpu_rdata, 0);
    applyStimulus(0, 1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge clk28);
    #1;
    rst_n = 1'b1;
    toBoundary();
    checkOutput("rstw_idle_oe", ram_oe_n, 1);
    checkOutput("rstw_idle_dq_oe", ram_dq_oe, 0);
    checkOutput("rstw_ram_a", ram_a, 0);
    tick();
    checkOutput("rstw_no_ack", cpuAckCount - cpuBase, 0);
    checkOutput("rstw_mem", mem[19'h40], 8'h1A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
